// File: rtl/ddr3_avl_arbiter.sv
// Two-master Avalon arbiter in front of the DDR3 controller: M0 writes (DVP capture), M1 reads (detection).
// Writes win by default; a bounded write streak and an outstanding-read budget keep reads flowing safely.
module ddr3_avl_arbiter #(
  parameter int MAX_WR_GRANTS = 4,
  parameter int MAX_PENDING   = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  m0_address,
  input  logic         m0_write,
  input  logic [127:0] m0_writedata,
  input  logic [15:0]  m0_byteenable,
  input  logic [9:0]   m0_burstcount,
  output logic         m0_waitrequest,
  input  logic [31:0]  m1_address,
  input  logic         m1_read,
  input  logic [9:0]   m1_burstcount,
  output logic         m1_waitrequest,
  output logic [127:0] m1_readdata,
  output logic         m1_readdatavalid,
  output logic [31:0]  avl_addr,
  output logic         avl_write_req,
  output logic         avl_read_req,
  output logic [127:0] avl_wdata,
  output logic [15:0]  avl_be,
  output logic [9:0]   avl_size,
  input  logic         avl_waitrequest,
  input  logic [127:0] avl_rdata,
  input  logic         avl_rdata_valid,
  output logic [10:0]  pend_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_CMD   = 2'd2;

  localparam logic [3:0]  MAX_WR = 4'(MAX_WR_GRANTS);
  localparam logic [10:0] MAX_P  = 11'(MAX_PENDING);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        armed;
  logic [9:0]  beats_left;
  logic [2:0]  wr_streak;
  logic        err_underflow;
  logic [31:0] addr_hold;
  logic [9:0]  size_hold;

  logic [9:0]  m0_eff;
  logic [9:0]  m1_eff;
  logic        read_ok;
  logic        streak_hit;
  logic        grant_wr;
  logic        grant_rd;
  logic        wr_beat;
  logic        wr_first;
  logic        wr_last;
  logic        rd_accept;
  logic [10:0] pend_sum;
  logic [10:0] pend_nxt;

  function automatic logic [9:0] eff_burst(input logic [9:0] b);
    return (b == 10'd0) ? 10'd1 : b;
  endfunction

  assign m0_eff     = eff_burst(m0_burstcount);
  assign m1_eff     = eff_burst(m1_burstcount);
  assign read_ok    = (pend_cnt + {1'b0, m1_eff}) <= MAX_P;
  assign streak_hit = {1'b0, wr_streak} >= MAX_WR;

  // armed blocks the very first cycle after reset release so a grant needs two edges
  assign grant_wr = armed && (state == IDLE) && m0_write &&
                    !(m1_read && read_ok && streak_hit);
  assign grant_rd = armed && (state == IDLE) && m1_read && read_ok &&
                    (!m0_write || streak_hit);

  // beats_left == 0 inside WR_BURST means the first beat has not been taken yet
  assign wr_beat   = (state == WR_BURST) && m0_write && !avl_waitrequest;
  assign wr_first  = (beats_left == 10'd0);
  assign wr_last   = wr_beat && (wr_first ? (m0_eff == 10'd1) : (beats_left == 10'd1));
  assign rd_accept = (state == RD_CMD) && m1_read && !avl_waitrequest;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_wr)      state_nxt = WR_BURST;
        else if (grant_rd) state_nxt = RD_CMD;
      end
      WR_BURST: if (wr_last) state_nxt = IDLE;
      RD_CMD:   if (rd_accept || !m1_read) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A valid beat with nothing outstanding is clamped at zero and flagged
  always_comb begin
    pend_sum = pend_cnt + (rd_accept ? {1'b0, m1_eff} : 11'd0);
    pend_nxt = pend_sum;
    if (avl_rdata_valid) pend_nxt = (pend_sum == 11'd0) ? 11'd0 : pend_sum - 11'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      beats_left    <= 10'd0;
      wr_streak     <= 3'd0;
      pend_cnt      <= 11'd0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      armed    <= 1'b1;
      pend_cnt <= pend_nxt;
      if (wr_beat) beats_left <= wr_first ? m0_eff - 10'd1 : beats_left - 10'd1;
      if (grant_rd)
        wr_streak <= 3'd0;
      else if (grant_wr && m1_read) begin
        if (wr_streak != 3'd7) wr_streak <= wr_streak + 3'd1;
      end else if ((state == IDLE) && !m1_read)
        wr_streak <= 3'd0;
      if (avl_rdata_valid && (pend_sum == 11'd0)) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_beat && wr_first) begin
      addr_hold <= m0_address;
      size_hold <= m0_burstcount;
    end
  end

  always_comb begin
    avl_addr       = 32'd0;
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_wdata      = 128'd0;
    avl_be         = 16'd0;
    avl_size       = 10'd0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      WR_BURST: begin
        avl_addr       = wr_first ? m0_address : addr_hold;
        avl_size       = wr_first ? m0_burstcount : size_hold;
        avl_write_req  = m0_write;
        avl_wdata      = m0_writedata;
        avl_be         = m0_byteenable;
        m0_waitrequest = avl_waitrequest;
      end
      RD_CMD: begin
        avl_addr       = m1_address;
        avl_size       = m1_burstcount;
        avl_read_req   = m1_read;
        m1_waitrequest = avl_waitrequest;
      end
      default: ;
    endcase
  end

  assign m1_readdata      = avl_rdata;
  assign m1_readdatavalid = avl_rdata_valid;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Scoreboard bench for ddr3_avl_arbiter: write beats and grant order are queued when driven
// and compared when the DUT presents them; read budget and reset behaviour checked directly.
module tb_ddr3_avl_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  m0_address;
  logic         m0_write;
  logic [127:0] m0_writedata;
  logic [15:0]  m0_byteenable;
  logic [9:0]   m0_burstcount;
  logic         m0_waitrequest;
  logic [31:0]  m1_address;
  logic         m1_read;
  logic [9:0]   m1_burstcount;
  logic         m1_waitrequest;
  logic [127:0] m1_readdata;
  logic         m1_readdatavalid;
  logic [31:0]  avl_addr;
  logic         avl_write_req;
  logic         avl_read_req;
  logic [127:0] avl_wdata;
  logic [15:0]  avl_be;
  logic [9:0]   avl_size;
  logic         avl_waitrequest;
  logic [127:0] avl_rdata;
  logic         avl_rdata_valid;
  logic [10:0]  pend_cnt;

  typedef struct packed {
    logic [31:0]  addr;
    logic [9:0]   size;
    logic [15:0]  be;
    logic [127:0] data;
  } wr_beat_t;

  wr_beat_t   wr_q[$];
  wr_beat_t   exp_e;
  logic [7:0] gq[$];
  int         checks = 0;
  int         failures = 0;
  int         wr_beats = 0;
  bit         sb_wr_en = 1'b1;

  ddr3_avl_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .avl_addr(avl_addr), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
    .avl_waitrequest(avl_waitrequest), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("cmd_excl", 256'(avl_write_req & avl_read_req), 256'(0));
    if (sb_wr_en && avl_write_req && !avl_waitrequest) begin
      wr_beats++;
      if (wr_q.size() == 0) chk("wr_unexpected", 256'(1), 256'(0));
      else begin
        exp_e = wr_q.pop_front();
        chk("wr_beat", 256'({avl_addr, avl_size, avl_be, avl_wdata}), 256'(exp_e));
      end
    end
  end

  task automatic m0_burst(input logic [31:0] addr, input logic [9:0] bc, input int stall_beat,
                          input int stall_cyc, input int gap_beat,
                          output int first_wait, output int m1_open);
    int nb, stall, waits;
    bit done;
    wr_beat_t e;
    nb = (bc == 10'd0) ? 1 : int'(bc);
    first_wait = 0; m1_open = 0; wr_beats = 0; stall = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == gap_beat) begin
        m0_write = 1'b0;
        step();
      end
      m0_write      = 1'b1;
      m0_address    = (i == 0) ? addr : $urandom;
      m0_burstcount = (i == 0) ? bc : 10'($urandom);
      m0_writedata  = {$urandom, $urandom, $urandom, $urandom};
      m0_byteenable = 16'($urandom);
      e = '{addr: addr, size: bc, be: m0_byteenable, data: m0_writedata};
      wr_q.push_back(e);
      if (i == stall_beat) begin
        avl_waitrequest = 1'b1;
        stall = stall_cyc;
      end
      waits = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (!m1_waitrequest) m1_open++;
        if (!m0_waitrequest) done = 1'b1;
        else begin
          waits++;
          if (waits > 40) begin
            chk("wr_timeout", 256'(waits), 256'(0));
            m0_write = 1'b0; avl_waitrequest = 1'b0; wr_q.delete();
            return;
          end
          step();
          if (stall > 0) begin
            stall--;
            if (stall == 0) avl_waitrequest = 1'b0;
          end
        end
      end
      if (i == 0) first_wait = waits;
      step();
    end
    m0_write = 1'b0;
    @(negedge clk);
    chk("wr_exit", 256'({avl_write_req, m0_waitrequest}), 256'(2'b01));
    chk("wr_beats", 256'(wr_beats), 256'(nb));
    step();
  endtask

  task automatic rd_cmd(input logic [31:0] addr, input logic [9:0] bc, output int waits);
    bit done;
    m1_address = addr; m1_burstcount = bc; m1_read = 1'b1;
    waits = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!m1_waitrequest) begin
        done = 1'b1;
        chk("rd_fwd", 256'({avl_read_req, avl_addr, avl_size}), 256'({1'b1, addr, bc}));
      end else begin
        waits++;
        if (waits > 40) begin
          chk("rd_timeout", 256'(waits), 256'(0));
          m1_read = 1'b0;
          return;
        end
        step();
      end
    end
    step();
    m1_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, mo, got, rd_open;
    logic [7:0] g, eg;
    logic [127:0] rdv;
    rst = 1'b1;
    m0_address = '0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0; m0_burstcount = '0;
    m1_address = '0; m1_read = 1'b0; m1_burstcount = '0;
    avl_waitrequest = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;

    @(negedge clk);
    chk("rst_outputs", 256'({avl_write_req, avl_read_req, m0_waitrequest, m1_waitrequest}), 256'(4'b0011));
    chk("rst_pend", 256'(pend_cnt), 256'(0));
    chk("rst_err", 256'(dut.err_underflow), 256'(0));
    step();
    rst = 1'b0;
    step(); step(); step();

    // single write, slave never stalls
    m0_burst(32'h1000_0040, 10'd4, -1, 0, -1, w, mo);
    chk("wr1_grant_lat", 256'(w), 256'(1));
    chk("wr1_m1_stalled", 256'(mo), 256'(0));

    // slave stalls the first beat (IDLE decision cycle + 3 stalled cycles)
    m0_burst(32'h1000_0100, 10'd2, 0, 4, -1, w, mo);
    chk("stall_wait", 256'(w), 256'(4));

    // idle beat inside a burst plus a later-beat stall
    m0_burst(32'h1000_0200, 10'd5, 3, 2, 2, w, mo);
    chk("gap_grant_lat", 256'(w), 256'(1));

    // burstcount 0 behaves as one beat
    m0_burst(32'h1000_0300, 10'd0, -1, 0, -1, w, mo);

    // starvation guard: both masters request continuously with 1-beat bursts
    sb_wr_en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      gq.push_back("W"); gq.push_back("W"); gq.push_back("W"); gq.push_back("W"); gq.push_back("R");
    end
    m0_address = 32'h2000_0000; m0_burstcount = 10'd1; m0_write = 1'b1;
    m1_address = 32'h2100_0000; m1_burstcount = 10'd1; m1_read = 1'b1;
    got = 0;
    for (int c = 0; c < 80 && got < 15; c++) begin
      @(negedge clk);
      if (!m0_waitrequest || !m1_waitrequest) begin
        g = !m0_waitrequest ? 8'h57 : 8'h52;
        eg = gq.pop_front();
        chk("grant_seq", 256'(g), 256'(eg));
        got++;
      end
      step();
    end
    if (got < 15) chk("grant_timeout", 256'(got), 256'(15));
    m0_write = 1'b0; m1_read = 1'b0;
    @(negedge clk);
    chk("pend_after_reads", 256'(pend_cnt), 256'(3));
    step();
    sb_wr_en = 1'b1;

    // drain the three beats, then one more that must clamp and flag
    avl_rdata_valid = 1'b1;
    step(); step(); step();
    avl_rdata_valid = 1'b0;
    @(negedge clk);
    chk("pend_drained", 256'(pend_cnt), 256'(0));
    chk("no_underflow_yet", 256'(dut.err_underflow), 256'(0));
    step();
    avl_rdata_valid = 1'b1;
    step();
    avl_rdata_valid = 1'b0;
    @(negedge clk);
    chk("pend_floor", 256'(pend_cnt), 256'(0));
    chk("underflow_flag", 256'(dut.err_underflow), 256'(1));
    step();

    // outstanding-read budget: 250 pending, an 8-beat read must wait for two returns
    rd_cmd(32'h3000_0000, 10'd250, w);
    chk("rd_grant_lat", 256'(w), 256'(1));
    @(negedge clk);
    chk("pend_250", 256'(pend_cnt), 256'(250));
    step();
    m1_address = 32'h3000_1000; m1_burstcount = 10'd8; m1_read = 1'b1;
    rd_open = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!m1_waitrequest || avl_read_req) rd_open++;
      step();
    end
    for (int c = 0; c < 4; c++) begin
      avl_rdata_valid = (c == 0 || c == 2);
      @(negedge clk);
      if (!m1_waitrequest || avl_read_req) rd_open++;
      if (c == 3) chk("pend_248", 256'(pend_cnt), 256'(248));
      step();
    end
    avl_rdata_valid = 1'b0;
    chk("rd_blocked", 256'(rd_open), 256'(0));
    @(negedge clk);
    chk("rd_granted_248", 256'({m1_waitrequest, avl_read_req}), 256'(2'b01));
    step();
    m1_read = 1'b0;
    @(negedge clk);
    chk("pend_256", 256'(pend_cnt), 256'(256));
    step();

    avl_rdata_valid = 1'b1;
    for (int i = 0; i < 251; i++) step();
    avl_rdata_valid = 1'b0;
    @(negedge clk);
    chk("pend_5", 256'(pend_cnt), 256'(5));
    step();

    // command accept and a returning beat in the same cycle
    m1_address = 32'h3100_0000; m1_burstcount = 10'd16; m1_read = 1'b1;
    @(negedge clk);
    chk("rd_idle_cycle", 256'(m1_waitrequest), 256'(1));
    step();
    rdv = {$urandom, $urandom, $urandom, $urandom};
    avl_rdata = rdv; avl_rdata_valid = 1'b1;
    @(negedge clk);
    chk("rd_accept", 256'(m1_waitrequest), 256'(0));
    chk("rdata_pass", 256'(m1_readdata), 256'(rdv));
    chk("rvalid_pass", 256'(m1_readdatavalid), 256'(1));
    step();
    m1_read = 1'b0; avl_rdata_valid = 1'b0;
    @(negedge clk);
    chk("pend_net_20", 256'(pend_cnt), 256'(20));
    step();

    rd_cmd(32'h3200_0000, 10'd0, w);
    @(negedge clk);
    chk("pend_bc0", 256'(pend_cnt), 256'(21));
    step();

    // reset on beat 3 of an 8-beat burst
    sb_wr_en = 1'b0;
    m0_address = 32'h4000_0000; m0_burstcount = 10'd8; m0_write = 1'b1;
    m0_writedata = {$urandom, $urandom, $urandom, $urandom}; m0_byteenable = 16'hffff;
    step(); step(); step();
    @(negedge clk);
    chk("mid_burst_active", 256'({avl_write_req, m0_waitrequest}), 256'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", 256'({avl_write_req, avl_read_req, m0_waitrequest, m1_waitrequest}), 256'(4'b0011));
    chk("async_rst_pend", 256'(pend_cnt), 256'(0));
    chk("async_rst_err", 256'(dut.err_underflow), 256'(0));
    m0_write = 1'b0;
    step(); step();
    rst = 1'b0;
    sb_wr_en = 1'b1;
    m0_burst(32'h4000_1000, 10'd3, -1, 0, -1, w, mo);
    chk("post_rst_grant_lat", 256'(w), 256'(2));

    chk("wr_q_empty", 256'(wr_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_avl_arbiter.md
DDR3_AVL_ARBITER -- requirements
Module: ddr3_avl_arbiter

Interface
REQ-001 Parameter: MAX_WR_GRANTS, default 4, consecutive write-burst grants allowed while a read waits.
REQ-002 Parameter: MAX_PENDING, default 256, maximum outstanding read beats.
REQ-003 Port: clk  in  1  system clock, 50 MHz, the only clock.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports, write master M0 (DVP capture path): m0_address in 32; m0_write in 1; m0_writedata in 128; m0_byteenable in 16; m0_burstcount in 10; m0_waitrequest out 1.
REQ-006 Ports, read master M1 (detection path): m1_address in 32; m1_read in 1; m1_burstcount in 10; m1_waitrequest out 1; m1_readdata out 128; m1_readdatavalid out 1.
REQ-007 Ports, DDR3 Avalon slave side: avl_addr out 32; avl_write_req out 1; avl_read_req out 1; avl_wdata out 128; avl_be out 16; avl_size out 10; avl_waitrequest in 1; avl_rdata in 128; avl_rdata_valid in 1.
REQ-008 Port: pend_cnt out 11, current count of outstanding read beats.

Function
REQ-009 FSM states: IDLE, WR_BURST, RD_CMD; the state is registered.
REQ-010 IDLE: avl_write_req=0, avl_read_req=0, m0_waitrequest=1, m1_waitrequest=1; the decision is registered, so a grant takes effect 1 cycle after the request is sampled.
REQ-011 Grant in IDLE, M0 request only: go to WR_BURST.
REQ-012 Grant in IDLE, M1 request only and read_ok: go to RD_CMD.
REQ-013 Grant in IDLE, both requesting: M0 wins unless wr_streak>=MAX_WR_GRANTS and read_ok, in which case M1 wins.
REQ-014 read_ok = (pend_cnt + eff_burst(m1_burstcount)) <= MAX_PENDING; the compare uses 11-bit arithmetic, no truncation.
REQ-015 eff_burst(b) = b when b != 0, otherwise 1; a burstcount of 0 is treated as a 1-beat burst.
REQ-016 wr_streak: a 3-bit counter; increments (saturating) on each WR_BURST grant made while m1_read=1; clears on every RD_CMD grant and whenever the arbiter is in IDLE with m1_read=0.
REQ-017 WR_BURST forwarding: M0 address, write, data, byteenable and burstcount pass combinationally to the avl_* outputs; m0_waitrequest=avl_waitrequest; m1_waitrequest=1.
REQ-018 WR_BURST beat counting: beats_left is loaded with eff_burst on the first accepted beat (m0_write=1 and avl_waitrequest=0); each accepted beat decrements it.
REQ-019 WR_BURST exit: on the cycle the final beat is accepted, go to IDLE; cycles with m0_write=0 inside a burst are idle beats and do not end the grant.
REQ-020 WR_BURST address/size: avl_addr and avl_size are captured at the first beat and held for the rest of the burst.
REQ-021 RD_CMD forwarding: M1 address, read and burstcount are forwarded; m1_waitrequest=avl_waitrequest; m0_waitrequest=1.
REQ-022 RD_CMD exit: when the command is accepted (m1_read=1 and avl_waitrequest=0), return to IDLE.
REQ-023 RD_CMD abort: if m1_read drops before acceptance, return to IDLE.
REQ-024 Read return path: m1_readdata=avl_rdata and m1_readdatavalid=avl_rdata_valid, combinational and independent of state; it overlaps write bursts.
REQ-025 pend_cnt update: +eff_burst on read-command accept and -1 on each avl_rdata_valid; both in the same cycle apply the net value.
REQ-026 pend_cnt floor: pend_cnt never underflows; a valid beat arriving at 0 holds the count at 0 and sets sticky flag err_underflow, an internal register visible to the bench.
REQ-027 Slave-side command legality: avl_write_req and avl_read_req are never both 1.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE; beats_left=0; wr_streak=0; pend_cnt=0; err_underflow=0.
REQ-029 While rst=1, outputs: avl_write_req=0; avl_read_req=0; m0_waitrequest=1; m1_waitrequest=1.
REQ-030 Reset mid-burst abandons the burst; after rst falls, the first grant occurs at the earliest 2 cycles later.

Verification
REQ-031 Single write: M0 burst of 4, avl_waitrequest=0 -> grant 1 cycle after request; 4 beats forwarded; IDLE after the 4th beat; M1 stalled throughout.
REQ-032 Waitrequest stall: M0 burst of 2, avl_waitrequest=1 for 3 cycles on beat 1 -> m0_waitrequest mirrors it; data held; exactly 2 beats counted.
REQ-033 Starvation guard: M0 and M1 both requesting continuously, bursts of 1 -> grant sequence W,W,W,W,R repeats.
REQ-034 Pending limit: pend_cnt=250, M1 requests a burst of 8 -> no read grant; after 2 avl_rdata_valid beats (pend_cnt=248) -> granted; pend_cnt=256.
REQ-035 Simultaneous update: read command of burst 16 accepted in the same cycle as one avl_rdata_valid with pend_cnt=5 -> pend_cnt=20.
REQ-036 Reset mid-burst: assert rst on beat 3 of a burst of 8 -> outputs go to reset values immediately; pend_cnt=0; a new M0 burst completes normally.
